pc_sequencer: RTL and testbench

- Owns the program counter and decides each cycle's next fetch address: sequential PC+4, conditional branch, `j`/`jal` jump, or `jr` register jump.
- Holds the PC during pipeline/memory stalls.
- A redirect that arrives while stalled is buffered and applied when the stall releases.
- Sits between the decode/branch-compare logic and the instruction memory address port.

---
 rtl/pc_sequencer_pkg.sv | 24 ++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/npc_target_calc.sv | 54 +++++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int          WIDTH_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  // Instruction size in bytes, and the word-to-byte shift for branch offsets.
  localparam int          INSTR_BYTES  = 4;
  localparam int          WORD_SHIFT   = 2;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    DS   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-side <-> PC sequencer bundle: redirect requests in, fetch address out.
interface pc_sequencer_if;

  logic        stall;
  logic        br_valid;
  logic [15:0] br_offset;
  logic        j_valid;
  logic [25:0] j_index;
  logic        jr_valid;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_misalign;
  logic        redirect_busy;

  // Decode / branch-compare side drives the requests.
  modport master (
    output stall, br_valid, br_offset, j_valid, j_index, jr_valid, jr_addr,
    input  pc, pc_plus4, pc_misalign, redirect_busy
  );

  // Sequencer side answers with the fetch address.
  modport slave (
    input  stall, br_valid, br_offset, j_valid, j_index, jr_valid, jr_addr,
    output pc, pc_plus4, pc_misalign, redirect_busy
  );

endinterface

// File: rtl/npc_target_calc.sv
// Combinational next-PC target calculation: pc+4, branch/jump/jr targets,
// and jr > j > br priority selection.
module npc_target_calc
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             br_valid,
  input  logic [15:0]      br_offset,
  input  logic             j_valid,
  input  logic [25:0]      j_index,
  input  logic             jr_valid,
  input  logic [31:0]      jr_addr,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] tgt,
  output sel_e             sel,
  output logic             misalign
);

  logic [31:0] br_ext;
  logic [31:0] br_disp;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;

  assign pc_plus4 = pc + WIDTH'(INSTR_BYTES);

  // Branch displacement is a signed word count; wrap-around is intentional.
  assign br_ext  = {{16{br_offset[15]}}, br_offset};
  assign br_disp = br_ext << WORD_SHIFT;
  assign br_tgt  = pc_plus4 + br_disp;
  assign j_tgt   = {pc_plus4[31:28], j_index, 2'b00};
  assign jr_tgt  = {jr_addr[31:2], 2'b00};

  // Priority select: jr beats j beats br; misalign only meaningful for jr.
  always_comb begin
    sel      = SEL_SEQ;
    tgt      = pc_plus4;
    misalign = 1'b0;
    if (jr_valid) begin
      sel      = SEL_JR;
      tgt      = jr_tgt;
      misalign = (jr_addr[1:0] != 2'b00);
    end else if (j_valid) begin
      sel = SEL_J;
      tgt = j_tgt;
    end else if (br_valid) begin
      sel = SEL_BR;
      tgt = br_tgt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: owns pc, holds on stall, buffers a redirect that
// arrives while stalled and applies it on release.
// Optional MIPS delay slot: define PC_SEQ_DELAY_SLOT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          WIDTH    = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] hold_q, hold_d;       // pending target (PEND) / slot target (DS)
  logic             hold_mis_q, hold_mis_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] tgt;
  sel_e             sel;
  logic             tgt_mis;
  logic             redir;

  npc_target_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .pc        (pc_q),
    .br_valid  (bus.br_valid),
    .br_offset (bus.br_offset),
    .j_valid   (bus.j_valid),
    .j_index   (bus.j_index),
    .jr_valid  (bus.jr_valid),
    .jr_addr   (bus.jr_addr),
    .pc_plus4  (pc_plus4),
    .tgt       (tgt),
    .sel       (sel),
    .misalign  (tgt_mis)
  );

  assign redir = (sel != SEL_SEQ);

  // Next-state and next-pc decision for RUN / PEND / DS.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    hold_mis_d = hold_mis_q;
    mis_d      = mis_q;
    unique case (state_q)
      RUN: begin
        if (!bus.stall) begin
          if (redir) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
            pc_d       = pc_plus4;
            mis_d      = 1'b0;
            hold_d     = tgt;
            hold_mis_d = tgt_mis;
            state_d    = DS;
`else
            pc_d  = tgt;
            mis_d = tgt_mis;
`endif
          end else begin
            pc_d  = pc_plus4;
            mis_d = 1'b0;
          end
        end else if (redir) begin
          hold_d     = tgt;
          hold_mis_d = tgt_mis;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (bus.stall) begin
          if (redir) begin
            hold_d     = tgt;
            hold_mis_d = tgt_mis;
          end
        end else begin
          // The buffered (older) redirect wins; any new one this cycle is dropped.
`ifdef PC_SEQ_DELAY_SLOT_EN
          pc_d    = pc_plus4;
          mis_d   = 1'b0;
          state_d = DS;
`else
          pc_d    = hold_q;
          mis_d   = hold_mis_q;
          state_d = RUN;
`endif
        end
      end
      DS: begin
`ifdef PC_SEQ_DELAY_SLOT_EN
        // Redirects in the delay slot are ignored.
        if (!bus.stall) begin
          pc_d    = hold_q;
          mis_d   = hold_mis_q;
          state_d = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      default: state_d = RUN;
    endcase
  end

  // State, pc and pending/slot registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      hold_q     <= '0;
      hold_mis_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      hold_mis_q <= hold_mis_d;
      mis_q      <= mis_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.pc_misalign   = mis_q;
  assign bus.redirect_busy = (state_q != RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (default build, no delay slot).
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        mis;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
  task automatic cyc(input string tag, input logic rst_i, input logic stall_i,
                     input logic br_v, input logic [15:0] br_o,
                     input logic j_v, input logic [25:0] j_i,
                     input logic jr_v, input logic [31:0] jr_a,
                     input logic [31:0] epc, input logic emis, input logic ebusy);
    exp_t e;
    @(negedge clk);
    reset         = rst_i;
    bus.stall     = stall_i;
    bus.br_valid  = br_v;
    bus.br_offset = br_o;
    bus.j_valid   = j_v;
    bus.j_index   = j_i;
    bus.jr_valid  = jr_v;
    bus.jr_addr   = jr_a;
    e.tag  = tag;
    e.pc   = epc;
    e.mis  = emis;
    e.busy = ebusy;
    q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: after each rising edge, pop an expectation and compare.
  initial begin
    exp_t e;
    logic [31:0] p4;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        p4 = e.pc + 32'd4;
        total++;
        if (bus.pc !== e.pc) begin
          bad++;
          $display("FAIL %s pc got=%h want=%h", e.tag, bus.pc, e.pc);
        end
        total++;
        if (bus.pc_plus4 !== p4) begin
          bad++;
          $display("FAIL %s pc_plus4 got=%h want=%h", e.tag, bus.pc_plus4, p4);
        end
        total++;
        if (bus.pc_misalign !== e.mis) begin
          bad++;
          $display("FAIL %s pc_misalign got=%b want=%b", e.tag, bus.pc_misalign, e.mis);
        end
        total++;
        if (bus.redirect_busy !== e.busy) begin
          bad++;
          $display("FAIL %s redirect_busy got=%b want=%b", e.tag, bus.redirect_busy, e.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog timeout pending=%0d want=0", q.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.stall     = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_offset = '0;
    bus.j_valid   = 1'b0;
    bus.j_index   = '0;
    bus.jr_valid  = 1'b0;
    bus.jr_addr   = '0;

    //    tag          rst  stl  br  br_off     j   j_idx      jr  jr_addr        pc             mis  busy
    cyc("reset",       1'b1,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3000, 1'b0,1'b0);
    cyc("seq1",        1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3004, 1'b0,1'b0);
    cyc("seq2",        1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3008, 1'b0,1'b0);
    cyc("seq3",        1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_300C, 1'b0,1'b0);
    cyc("seq4",        1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3010, 1'b0,1'b0);
    // 0x3014 - 16 = 0x3004
    cyc("br_back",     1'b0,1'b0,1'b1,16'hFFFC, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3004, 1'b0,1'b0);
    cyc("seq5",        1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3008, 1'b0,1'b0);
    // 0x300C + 12 = 0x3018
    cyc("br_fwd",      1'b0,1'b0,1'b1,16'h0003, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3018, 1'b0,1'b0);

    cyc("reset2",      1'b1,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3000, 1'b0,1'b0);
    // jr beats j and br; target 0x4002 aligns down and flags misalign
    cyc("jr_prio",     1'b0,1'b0,1'b1,16'h0005, 1'b1,26'h100,  1'b1,32'h0000_4002,32'h0000_4000, 1'b1,1'b0);
    cyc("jr_seq",      1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_4004, 1'b0,1'b0);

    cyc("reset3",      1'b1,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3000, 1'b0,1'b0);
    cyc("seq6",        1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3004, 1'b0,1'b0);
    cyc("seq7",        1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3008, 1'b0,1'b0);
    // j captured while stalled: {0, 0x0C40, 00} = 0x3100
    cyc("stall_j",     1'b0,1'b1,1'b0,16'h0000, 1'b1,26'h0C40, 1'b0,32'h0,        32'h0000_3008, 1'b0,1'b1);
    cyc("stall2",      1'b0,1'b1,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3008, 1'b0,1'b1);
    cyc("stall3",      1'b0,1'b1,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3008, 1'b0,1'b1);
    cyc("release_br",  1'b0,1'b0,1'b1,16'h0010, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3100, 1'b0,1'b0);
    cyc("after_rel",   1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3104, 1'b0,1'b0);

    cyc("seq8",        1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3108, 1'b0,1'b0);
    cyc("pend_br",     1'b0,1'b1,1'b1,16'h0005, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3108, 1'b0,1'b1);
    cyc("reset_pend",  1'b1,1'b1,1'b0,16'h0000, 1'b1,26'h0C40, 1'b0,32'h0,        32'h0000_3000, 1'b0,1'b0);
    cyc("post_rst",    1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_3004, 1'b0,1'b0);

    // misalign holds through a stall, clears on next sequential load
    cyc("jr_mis",      1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b1,32'h0000_5003,32'h0000_5000, 1'b1,1'b0);
    cyc("mis_stall",   1'b0,1'b1,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_5000, 1'b1,1'b0);
    cyc("mis_clr",     1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_5004, 1'b0,1'b0);
    // j beats br: {0, 0x40, 00} = 0x100
    cyc("j_over_br",   1'b0,1'b0,1'b1,16'h0007, 1'b1,26'h40,   1'b0,32'h0,        32'h0000_0100, 1'b0,1'b0);
    // stalled jr sets pending misalign, applied on release
    cyc("pend_jr",     1'b0,1'b1,1'b0,16'h0000, 1'b0,26'h0,    1'b1,32'h0000_6001,32'h0000_0100, 1'b0,1'b1);
    cyc("rel_jr",      1'b0,1'b0,1'b0,16'h0000, 1'b0,26'h0,    1'b0,32'h0,        32'h0000_6000, 1'b1,1'b0);
    // branch wrap below zero: 0x6004 + (-0x1802*4) wraps to 0xFFFF_FFFC... computed: 0x6004 - 0x6008
    cyc("br_wrap",     1'b0,1'b0,1'b1,16'hE7FE, 1'b0,26'h0,    1'b0,32'h0,        32'hFFFF_FFFC, 1'b0,1'b0);

    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
